// File: rtl/sized_fifo_pkg.sv
// Shared helpers for the sized FIFO: width calculation and wrap-around pointer step.
package sized_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Step a pointer by one, wrapping at depth so non-power-of-two depths work.
  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Unreset WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sized_fifo_lvl.sv
// Depth-sized single-clock FIFO with occupancy level and sticky overflow/underflow flags.
module sized_fifo_lvl
  import sized_fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNTW  = clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             ENQ,
  output logic             FULL_N,
  input  logic             DEQ,
  output logic             EMPTY_N,
  output logic [WIDTH-1:0] D_OUT,
  output logic [CNTW-1:0]  LEVEL,
  output logic             OVF,
  output logic             UNF
);

  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            full, empty, deq_ok, enq_ok;

  assign full   = (cnt_q == CNTW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign deq_ok = DEQ & ~empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign enq_ok = ENQ & (~full | deq_ok);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (CLR) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (ENQ & ~enq_ok) ovf_d = 1'b1;
      if (DEQ & empty)   unf_d = 1'b1;
      if (deq_ok) rd_d = PW'(ptr_inc(int'(rd_q), DEPTH));
      if (enq_ok) wr_d = PW'(ptr_inc(int'(wr_q), DEPTH));
      if (enq_ok & ~deq_ok)      cnt_d = cnt_q + CNTW'(1);
      else if (deq_ok & ~enq_ok) cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  fifo_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_rf (
    .clk   (CLK),
    .we    (enq_ok & ~CLR & ~RST),
    .waddr (wr_q),
    .wdata (D_IN),
    .raddr (rd_q),
    .rdata (D_OUT)
  );

  assign FULL_N  = ~full;
  assign EMPTY_N = ~empty;
  assign LEVEL   = cnt_q;
  assign OVF     = ovf_q;
  assign UNF     = unf_q;

endmodule

// File: tb/tb_sized_fifo_lvl.sv
// Directed vector table on a DEPTH=3 FIFO plus randomized traffic on DEPTH=5 against a queue model.
module tb_sized_fifo_lvl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // DUT A: DEPTH=3, WIDTH=8
  logic       a_rst, a_clr, a_enq, a_deq;
  logic [7:0] a_din, a_dout;
  logic       a_full_n, a_empty_n, a_ovf, a_unf;
  logic [1:0] a_lvl;

  sized_fifo_lvl #(.WIDTH(8), .DEPTH(3)) dut_a (
    .CLK(CLK), .RST(a_rst), .CLR(a_clr), .D_IN(a_din), .ENQ(a_enq),
    .FULL_N(a_full_n), .DEQ(a_deq), .EMPTY_N(a_empty_n), .D_OUT(a_dout),
    .LEVEL(a_lvl), .OVF(a_ovf), .UNF(a_unf)
  );

  // DUT B: DEPTH=5, WIDTH=16
  logic        b_rst, b_clr, b_enq, b_deq;
  logic [15:0] b_din, b_dout;
  logic        b_full_n, b_empty_n, b_ovf, b_unf;
  logic [2:0]  b_lvl;

  sized_fifo_lvl #(.WIDTH(16), .DEPTH(5)) dut_b (
    .CLK(CLK), .RST(b_rst), .CLR(b_clr), .D_IN(b_din), .ENQ(b_enq),
    .FULL_N(b_full_n), .DEQ(b_deq), .EMPTY_N(b_empty_n), .D_OUT(b_dout),
    .LEVEL(b_lvl), .OVF(b_ovf), .UNF(b_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic       rst, clr, enq, deq;
    logic [7:0] d;
    int         lvl;
    logic       full_n, empty_n, ovf, unf;
    logic       chk_dout;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic clr, logic enq, logic deq, logic [7:0] d,
                              int lvl, logic fn, logic en, logic ovf, logic unf,
                              logic cd, logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.clr = clr; v.enq = enq; v.deq = deq; v.d = d;
    v.lvl = lvl; v.full_n = fn; v.empty_n = en; v.ovf = ovf; v.unf = unf;
    v.chk_dout = cd; v.dout = dout;
    return v;
  endfunction

  // Reference model for the random run.
  logic [15:0] mq[$];
  logic        m_ovf, m_unf;

  initial begin
    a_rst = 1'b1; a_clr = 1'b0; a_enq = 1'b0; a_deq = 1'b0; a_din = '0;
    b_rst = 1'b1; b_clr = 1'b0; b_enq = 1'b0; b_deq = 1'b0; b_din = '0;

    //                rst clr enq deq  d      lvl fn en ovf unf cd dout
    tv.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 0, 1, 0, 8'h11, 1, 1, 1, 0, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 1, 0, 8'h22, 2, 1, 1, 0, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 1, 0, 8'h33, 3, 0, 1, 0, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 1, 0, 8'h44, 3, 0, 1, 1, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 2, 1, 1, 1, 0, 1, 8'h22));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 1, 1, 0, 1, 8'h33));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00));
    tv.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 0, 1, 0, 8'h01, 1, 1, 1, 0, 0, 1, 8'h01));
    tv.push_back(mk(0, 0, 1, 0, 8'h02, 2, 1, 1, 0, 0, 1, 8'h01));
    tv.push_back(mk(0, 0, 1, 0, 8'h03, 3, 0, 1, 0, 0, 1, 8'h01));
    // full with simultaneous enq+deq: pointers wrap twice
    for (int i = 0; i < 6; i++)
      tv.push_back(mk(0, 0, 1, 1, 8'(4 + i), 3, 0, 1, 0, 0, 1, 8'(2 + i)));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 2, 1, 1, 0, 0, 1, 8'h08));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 1, 0, 0, 1, 8'h09));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    // empty with enq+deq: no bypass, underflow flagged
    tv.push_back(mk(0, 0, 1, 1, 8'h5A, 1, 1, 1, 0, 1, 1, 8'h5A));
    tv.push_back(mk(0, 0, 1, 0, 8'h66, 2, 1, 1, 0, 1, 1, 8'h5A));
    tv.push_back(mk(0, 0, 1, 0, 8'h67, 3, 0, 1, 0, 1, 1, 8'h5A));
    tv.push_back(mk(0, 0, 1, 0, 8'h68, 3, 0, 1, 1, 1, 1, 8'h5A));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 2, 1, 1, 1, 1, 1, 8'h66));
    tv.push_back(mk(0, 1, 1, 1, 8'h99, 0, 1, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 0, 1, 0, 8'h77, 1, 1, 1, 0, 0, 1, 8'h77));
    // reset mid-stream discards data; next enqueue is the new head
    tv.push_back(mk(0, 0, 1, 0, 8'h78, 2, 1, 1, 0, 0, 1, 8'h77));
    tv.push_back(mk(1, 0, 1, 1, 8'hAA, 0, 1, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 0, 1, 0, 8'hBB, 1, 1, 1, 0, 0, 1, 8'hBB));

    for (int i = 0; i < tv.size(); i++) begin
      a_rst = tv[i].rst; a_clr = tv[i].clr; a_enq = tv[i].enq;
      a_deq = tv[i].deq; a_din = tv[i].d;
      tick();
      chk($sformatf("v%0d level", i),   32'(a_lvl),     32'(tv[i].lvl));
      chk($sformatf("v%0d full_n", i),  32'(a_full_n),  32'(tv[i].full_n));
      chk($sformatf("v%0d empty_n", i), 32'(a_empty_n), 32'(tv[i].empty_n));
      chk($sformatf("v%0d ovf", i),     32'(a_ovf),     32'(tv[i].ovf));
      chk($sformatf("v%0d unf", i),     32'(a_unf),     32'(tv[i].unf));
      if (tv[i].chk_dout)
        chk($sformatf("v%0d d_out", i), 32'(a_dout), 32'(tv[i].dout));
    end
    a_rst = 1'b0; a_clr = 1'b0; a_enq = 1'b0; a_deq = 1'b0;

    // Random run on DUT B
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bit e, d, cl, d_ok, e_ok;
      e  = ($urandom_range(0, 99) < 55);
      d  = ($urandom_range(0, 99) < 50);
      cl = ($urandom_range(0, 199) == 0);
      b_enq = e; b_deq = d; b_clr = cl; b_din = 16'($urandom);
      if (mq.size() != 0)
        chk($sformatf("r%0d d_out", c), 32'(b_dout), 32'(mq[0]));
      if (cl) begin
        mq.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        d_ok = d && (mq.size() != 0);
        e_ok = e && ((mq.size() < 5) || d_ok);
        if (d && mq.size() == 0) m_unf = 1'b1;
        if (e && !e_ok)          m_ovf = 1'b1;
        if (d_ok) void'(mq.pop_front());
        if (e_ok) mq.push_back(b_din);
      end
      tick();
      chk($sformatf("r%0d level", c),   32'(b_lvl),     32'(mq.size()));
      chk($sformatf("r%0d full_n", c),  32'(b_full_n),  32'(mq.size() != 5));
      chk($sformatf("r%0d empty_n", c), 32'(b_empty_n), 32'(mq.size() != 0));
      chk($sformatf("r%0d ovf", c),     32'(b_ovf),     32'(m_ovf));
      chk($sformatf("r%0d unf", c),     32'(b_unf),     32'(m_unf));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
